fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch-stage sequencer that drives the program counter's next-address input and stall, and flushes the front-end pipeline registers. Each cycle it chooses the next PC by priority: trap vector, EX-stage branch target, ID-stage jump target, hold (hazard or memory wait), or sequential PC+4. A small state machine covers boot, normal run, instruction-memory wait and a pending redirect that arrives while memory is busy.

Parameters:
INST_MEMORY_SIZE, 16384, instruction memory size in bytes
ADDR_WIDTH, $clog2(INST_MEMORY_SIZE), number of PC bits actually used
RESET_VECTOR, 64'h0, first fetch address after reset
TRAP_VECTOR, 64'h100, redirect target for trap_req and for a misaligned target

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
pc_cur  in  64  current PC from the program counter (zero-extended)
hazard_stall  in  1  load-use stall request from ID
br_taken_ex  in  1  taken branch resolved in EX
br_target_ex  in  64  branch target
jmp_id  in  1  unconditional jump decoded in ID
jmp_target_id  in  64  jump target
trap_req  in  1  trap/exception request
imem_ready  in  1  instruction memory has returned the word for pc_cur
pc_next  out  64  next-address input to the program counter
pc_stall  out  1  program counter hold
if_id_flush  out  1  invalidate IF/ID register
id_ex_flush  out  1  invalidate ID/EX register
fetch_valid  out  1  the instruction at pc_cur is valid this cycle
misalign_err  out  1  one-cycle pulse when a redirect target has bits[1:0] != 0

Behaviour:
- Reset is synchronous and active-low on clk (reset_n), and is honoured in every state.
- While reset is asserted and in the cycle after it: state BOOT, pc_next=RESET_VECTOR, pc_stall=1, all flushes 0, fetch_valid=0, misalign_err=0, pending register cleared.
- States:
  - BOOT: always goes to RUN on the next cycle.
  - RUN: normal sequencing.
  - MEM_WAIT: entered when imem_ready=0 in RUN.
  - REDIR_PEND: a redirect was captured while in MEM_WAIT.
- RUN priority, evaluated combinationally in the same cycle:
  1. trap_req: pc_next=TRAP_VECTOR, if_id_flush=1, id_ex_flush=1.
  2. br_taken_ex: pc_next=br_target_ex, if_id_flush=1, id_ex_flush=1.
  3. jmp_id: pc_next=jmp_target_id, if_id_flush=1.
  4. hazard_stall: pc_stall=1, pc_next=pc_cur, no flush.
  5. Otherwise: pc_next=pc_cur+4.
  - A redirect (items 1-3) overrides hazard_stall and imem_ready, so pc_stall=0 in that cycle.
- fetch_valid = imem_ready in RUN, and 0 in every other state.
- RUN with imem_ready=0 and no redirect: pc_stall=1; go to MEM_WAIT.
- MEM_WAIT:
  - pc_stall=1; fetch_valid=0.
  - A redirect arriving here: latch the winning target by the same priority into pend_target, assert the flushes for that request in that cycle, go to REDIR_PEND.
  - imem_ready=1 with no redirect: go to RUN; sequential advance resumes in that RUN cycle.
- REDIR_PEND:
  - pc_stall=1 until imem_ready=1.
  - Then pc_stall=0, pc_next=pend_target, if_id_flush=1, fetch_valid=0; go to RUN.
  - A higher-priority redirect (trap over branch over jump) arriving while pending overwrites pend_target; a lower-priority one is dropped.
- Target check: if the selected target has bits[1:0] != 0, pulse misalign_err and use TRAP_VECTOR instead. Both flushes assert.
- Width rules:
  - All arithmetic is done on ADDR_WIDTH bits; pc_next[63:ADDR_WIDTH]=0.
  - Targets are truncated to ADDR_WIDTH.
  - pc_cur+4 wraps modulo 2^ADDR_WIDTH.
- A redirect in the same cycle as reset is ignored.

Decomposition:
- Shared package fetch_pkg holds the state enum (BOOT, RUN, MEM_WAIT, REDIR_PEND), the redirect-source encoding (NONE, TRAP, BRANCH, JUMP), and the INSTR_BYTES=4 constant.
- One natural sub-module, redirect_sel: combinational priority select and misalignment check. Its outputs are target, source code and misalign flag.

Test Plan:
- Reset, then release with imem_ready=1 -> one cycle pc_stall=1, pc_next=0; then pc_next = 4, 8, 12 on consecutive cycles with fetch_valid=1.
- pc_cur=0x20, br_taken_ex=1, br_target_ex=0x80, jmp_id=1 in the same cycle -> pc_next=0x80 (branch wins), if_id_flush=1, id_ex_flush=1.
- pc_cur=0x30 with hazard_stall=1 for 2 cycles -> pc_stall=1, pc_next=0x30 both cycles, no flush; next cycle pc_next=0x34.
- imem_ready=0 for 3 cycles, jmp_id=1 (target 0x200) in the second cycle -> stall held throughout; when ready returns, pc_next=0x200, if_id_flush=1, state back to RUN.
- br_target_ex=0x102 taken -> misalign_err pulses for 1 cycle, pc_next=0x100, both flushes asserted.
- pc_cur=0x3FFC with ADDR_WIDTH=14 and no events -> pc_next=0x0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch-stage sequencer:
// FSM states, redirect sources and instruction size.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MEM_WAIT,
    REDIR_PEND
  } fetch_state_e;

  // Encoding order doubles as priority: lower value wins.
  typedef enum logic [1:0] {
    NONE,
    TRAP,
    BRANCH,
    JUMP
  } redir_src_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl_redirect_sel.sv
// Priority select among trap, branch and jump redirects,
// with misaligned targets forced onto the trap vector.
module redirect_sel
  import fetch_pkg::*;
#(
  parameter int          AW          = 14,
  parameter logic [63:0] TRAP_VECTOR = 64'h100
) (
  input  logic          i_trap_req,
  input  logic          i_br_taken,
  input  logic [AW-1:0] i_br_target,
  input  logic          i_jmp,
  input  logic [AW-1:0] i_jmp_target,
  output logic [AW-1:0] o_target,
  output redir_src_e    o_src,
  output logic          o_misalign
);

  localparam logic [AW-1:0] TRAP_A = TRAP_VECTOR[AW-1:0];

  logic [AW-1:0] w_raw;

  always_comb begin
    w_raw = '0;
    o_src = NONE;
    if (i_trap_req) begin
      o_src = TRAP;
      w_raw = TRAP_A;
    end else if (i_br_taken) begin
      o_src = BRANCH;
      w_raw = i_br_target;
    end else if (i_jmp) begin
      o_src = JUMP;
      w_raw = i_jmp_target;
    end
  end

  assign o_misalign = (o_src != NONE) && (w_raw[1:0] != 2'b00);
  assign o_target   = o_misalign ? TRAP_A : w_raw;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: next-PC selection, PC stall,
// front-end flushes and instruction-memory wait handling.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          INST_MEMORY_SIZE = 16384,
  parameter int          ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
  parameter logic [63:0] RESET_VECTOR     = 64'h0,
  parameter logic [63:0] TRAP_VECTOR      = 64'h100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] pc_cur,
  input  logic        hazard_stall,
  input  logic        br_taken_ex,
  input  logic [63:0] br_target_ex,
  input  logic        jmp_id,
  input  logic [63:0] jmp_target_id,
  input  logic        trap_req,
  input  logic        imem_ready,
  output logic [63:0] pc_next,
  output logic        pc_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        fetch_valid,
  output logic        misalign_err
);

  localparam int            AW    = ADDR_WIDTH;
  localparam logic [AW-1:0] RST_A = RESET_VECTOR[AW-1:0];
  localparam logic [AW-1:0] STEP  = AW'(INSTR_BYTES);

  fetch_state_e  r_state;
  logic [AW-1:0] r_pend_tgt;
  redir_src_e    r_pend_src;

  fetch_state_e  w_state_n;
  logic [AW-1:0] w_pend_tgt_n;
  redir_src_e    w_pend_src_n;
  logic [AW-1:0] w_pc;
  logic          w_stall;
  logic          w_if_fl;
  logic          w_ex_fl;
  logic          w_fv;
  logic          w_mis;

  logic [AW-1:0] w_sel_tgt;
  redir_src_e    w_sel_src;
  logic          w_sel_mis;
  logic          w_req;
  logic          w_ex_req;
  logic          w_take;
  logic          w_unused;

  redirect_sel #(
    .AW          (AW),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_sel (
    .i_trap_req   (trap_req),
    .i_br_taken   (br_taken_ex),
    .i_br_target  (br_target_ex[AW-1:0]),
    .i_jmp        (jmp_id),
    .i_jmp_target (jmp_target_id[AW-1:0]),
    .o_target     (w_sel_tgt),
    .o_src        (w_sel_src),
    .o_misalign   (w_sel_mis)
  );

  assign w_req    = (w_sel_src != NONE);
  assign w_ex_req = (w_sel_src == TRAP) ||
                    (w_sel_src == BRANCH) ||
                    w_sel_mis;
  assign w_take   = w_req && (w_sel_src < r_pend_src);

  always_comb begin
    w_state_n    = r_state;
    w_pend_tgt_n = r_pend_tgt;
    w_pend_src_n = r_pend_src;
    w_pc         = pc_cur[AW-1:0];
    w_stall      = 1'b1;
    w_if_fl      = 1'b0;
    w_ex_fl      = 1'b0;
    w_fv         = 1'b0;
    w_mis        = 1'b0;
    if (!reset_n) begin
      w_pc = RST_A;
    end else begin
      unique case (r_state)
        BOOT: begin
          w_pc      = RST_A;
          w_state_n = RUN;
        end
        RUN: begin
          w_fv = imem_ready;
          if (w_req) begin
            w_pc    = w_sel_tgt;
            w_stall = 1'b0;
            w_if_fl = 1'b1;
            w_ex_fl = w_ex_req;
            w_mis   = w_sel_mis;
          end else if (hazard_stall || !imem_ready) begin
            w_state_n = imem_ready ? RUN : MEM_WAIT;
          end else begin
            w_pc    = pc_cur[AW-1:0] + STEP;
            w_stall = 1'b0;
          end
        end
        MEM_WAIT: begin
          if (w_req) begin
            w_if_fl      = 1'b1;
            w_ex_fl      = w_ex_req;
            w_mis        = w_sel_mis;
            w_pend_tgt_n = w_sel_tgt;
            w_pend_src_n = w_sel_src;
            w_state_n    = REDIR_PEND;
          end else if (imem_ready) begin
            w_state_n = RUN;
          end
        end
        REDIR_PEND: begin
          // Only a strictly higher-priority source replaces the pending one.
          if (w_take) begin
            w_if_fl      = 1'b1;
            w_ex_fl      = w_ex_req;
            w_mis        = w_sel_mis;
            w_pend_tgt_n = w_sel_tgt;
            w_pend_src_n = w_sel_src;
          end
          if (imem_ready) begin
            w_pc         = w_pend_tgt_n;
            w_stall      = 1'b0;
            w_if_fl      = 1'b1;
            w_pend_src_n = NONE;
            w_state_n    = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= BOOT;
      r_pend_tgt <= '0;
      r_pend_src <= NONE;
    end else begin
      r_state    <= w_state_n;
      r_pend_tgt <= w_pend_tgt_n;
      r_pend_src <= w_pend_src_n;
    end
  end

  assign pc_next      = {{(64-AW){1'b0}}, w_pc};
  assign pc_stall     = w_stall;
  assign if_id_flush  = w_if_fl;
  assign id_ex_flush  = w_ex_fl;
  assign fetch_valid  = w_fv;
  assign misalign_err = w_mis;

  assign w_unused = &{1'b0,
                      pc_cur[63:AW],
                      br_target_ex[63:AW],
                      jmp_target_id[63:AW]};

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized checks of fetch_ctrl against a
// cycle-level reference model of the sequencing rules.
module tb_fetch_ctrl;

  localparam logic [63:0] MASK  = 64'h3FFF;
  localparam logic [63:0] TRAPV = 64'h100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] pc_cur;
  logic        hazard_stall;
  logic        br_taken_ex;
  logic [63:0] br_target_ex;
  logic        jmp_id;
  logic [63:0] jmp_target_id;
  logic        trap_req;
  logic        imem_ready;
  logic [63:0] pc_next;
  logic        pc_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        fetch_valid;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_cur        (pc_cur),
    .hazard_stall  (hazard_stall),
    .br_taken_ex   (br_taken_ex),
    .br_target_ex  (br_target_ex),
    .jmp_id        (jmp_id),
    .jmp_target_id (jmp_target_id),
    .trap_req      (trap_req),
    .imem_ready    (imem_ready),
    .pc_next       (pc_next),
    .pc_stall      (pc_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .fetch_valid   (fetch_valid),
    .misalign_err  (misalign_err)
  );

  int tests = 0;
  int fails = 0;

  // Model: mode 0 boot, 1 run, 2 waiting on memory, 3 redirect pending.
  int          m_mode  = 0;
  logic [63:0] m_ptgt  = '0;
  int          m_prank = 0;
  int          n_mode;
  logic [63:0] n_ptgt;
  int          n_prank;

  logic [63:0] e_pc;
  logic        e_stall, e_if, e_ex, e_fv, e_mis;
  logic [63:0] s_pc;
  logic        s_stall, s_if, s_ex, s_fv, s_mis;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    int          rank;
    logic [63:0] raw;
    logic [63:0] tgt;
    bit          mis;
    bit          exf;
    bit          take;
    rank = 0;
    raw  = '0;
    if (trap_req) begin
      rank = 1; raw = TRAPV;
    end else if (br_taken_ex) begin
      rank = 2; raw = br_target_ex & MASK;
    end else if (jmp_id) begin
      rank = 3; raw = jmp_target_id & MASK;
    end
    mis = (rank != 0) && ((raw % 4) != 0);
    tgt = mis ? TRAPV : raw;
    exf = (rank == 1) || (rank == 2) || mis;
    e_pc = pc_cur & MASK;
    e_stall = 1; e_if = 0; e_ex = 0; e_fv = 0; e_mis = 0;
    n_mode = m_mode; n_ptgt = m_ptgt; n_prank = m_prank;
    if (!reset_n) begin
      e_pc = 0; n_mode = 0; n_ptgt = 0; n_prank = 0;
    end else if (m_mode == 0) begin
      e_pc = 0; n_mode = 1;
    end else if (m_mode == 1) begin
      e_fv = imem_ready;
      if (rank != 0) begin
        e_pc = tgt; e_stall = 0; e_if = 1; e_ex = exf; e_mis = mis;
      end else if (hazard_stall || !imem_ready) begin
        n_mode = imem_ready ? 1 : 2;
      end else begin
        e_pc = (pc_cur + 4) & MASK; e_stall = 0;
      end
    end else if (m_mode == 2) begin
      if (rank != 0) begin
        e_if = 1; e_ex = exf; e_mis = mis;
        n_ptgt = tgt; n_prank = rank; n_mode = 3;
      end else if (imem_ready) begin
        n_mode = 1;
      end
    end else begin
      take = (rank != 0) && (rank < m_prank);
      if (take) begin
        e_if = 1; e_ex = exf; e_mis = mis;
        n_ptgt = tgt; n_prank = rank;
      end
      if (imem_ready) begin
        e_pc = n_ptgt; e_stall = 0; e_if = 1;
        n_mode = 1; n_prank = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    predict();
    @(negedge clk);
    s_pc = pc_next; s_stall = pc_stall; s_if = if_id_flush;
    s_ex = id_ex_flush; s_fv = fetch_valid; s_mis = misalign_err;
    chk({tag, ".pc_next"}, s_pc, e_pc);
    chk({tag, ".pc_stall"}, 64'(s_stall), 64'(e_stall));
    chk({tag, ".if_id_flush"}, 64'(s_if), 64'(e_if));
    chk({tag, ".id_ex_flush"}, 64'(s_ex), 64'(e_ex));
    chk({tag, ".fetch_valid"}, 64'(s_fv), 64'(e_fv));
    chk({tag, ".misalign_err"}, 64'(s_mis), 64'(e_mis));
    m_mode = n_mode; m_ptgt = n_ptgt; m_prank = n_prank;
    @(posedge clk);
    #1;
    if (!reset_n) pc_cur = 64'h0;
    else if (!e_stall) pc_cur = e_pc;
  endtask

  initial begin
    reset_n = 0; pc_cur = 0; hazard_stall = 0;
    br_taken_ex = 0; br_target_ex = 0; jmp_id = 0;
    jmp_target_id = 0; trap_req = 0; imem_ready = 1;
    tick("rst0");
    tick("rst1");
    chk("rst_stall", 64'(s_stall), 64'd1);
    reset_n = 1;
    tick("boot");
    chk("boot_stall", 64'(s_stall), 64'd1);
    chk("boot_pc", s_pc, 64'h0);
    tick("seq1");
    chk("seq_4", s_pc, 64'h4);
    chk("seq_fv", 64'(s_fv), 64'd1);
    tick("seq2");
    chk("seq_8", s_pc, 64'h8);
    tick("seq3");
    chk("seq_12", s_pc, 64'hC);

    pc_cur = 64'h20; br_taken_ex = 1; br_target_ex = 64'h80;
    jmp_id = 1; jmp_target_id = 64'h300;
    tick("brwin");
    chk("brwin_pc", s_pc, 64'h80);
    chk("brwin_ex", 64'(s_ex), 64'd1);
    br_taken_ex = 0; jmp_id = 0;

    pc_cur = 64'h30; hazard_stall = 1;
    tick("haz1");
    chk("haz1_pc", s_pc, 64'h30);
    tick("haz2");
    chk("haz2_stall", 64'(s_stall), 64'd1);
    hazard_stall = 0;
    tick("haz3");
    chk("haz3_pc", s_pc, 64'h34);

    imem_ready = 0;
    tick("mw1");
    jmp_id = 1; jmp_target_id = 64'h200;
    tick("mw2");
    chk("mw2_flush", 64'(s_if), 64'd1);
    chk("mw2_stall", 64'(s_stall), 64'd1);
    jmp_id = 0;
    tick("mw3");
    imem_ready = 1;
    tick("pend");
    chk("pend_pc", s_pc, 64'h200);
    chk("pend_fv", 64'(s_fv), 64'd0);
    tick("back");
    chk("back_pc", s_pc, 64'h204);
    chk("back_fv", 64'(s_fv), 64'd1);

    br_taken_ex = 1; br_target_ex = 64'h102;
    tick("mis");
    chk("mis_err", 64'(s_mis), 64'd1);
    chk("mis_pc", s_pc, 64'h100);
    br_taken_ex = 0;
    tick("mis_end");
    chk("mis_pulse", 64'(s_mis), 64'd0);

    pc_cur = 64'h3FFC;
    tick("wrap");
    chk("wrap_pc", s_pc, 64'h0);

    imem_ready = 0;
    tick("ov1");
    jmp_id = 1; jmp_target_id = 64'h400;
    tick("ov2");
    jmp_id = 0; trap_req = 1;
    tick("ov3");
    chk("ov3_ex", 64'(s_ex), 64'd1);
    trap_req = 0; br_taken_ex = 1; br_target_ex = 64'h500;
    tick("ov4");
    chk("ov4_drop", 64'(s_if), 64'd0);
    br_taken_ex = 0; imem_ready = 1;
    tick("ov5");
    chk("ov5_pc", s_pc, 64'h100);

    reset_n = 0; trap_req = 1;
    tick("rst_redir");
    chk("rst_redir_if", 64'(s_if), 64'd0);
    trap_req = 0; reset_n = 1;
    tick("reboot");

    for (int i = 0; i < 3000; i++) begin
      reset_n      = ($urandom_range(0, 63) != 0);
      trap_req     = ($urandom_range(0, 19) == 0);
      br_taken_ex  = ($urandom_range(0, 7) == 0);
      jmp_id       = ($urandom_range(0, 7) == 0);
      hazard_stall = ($urandom_range(0, 5) == 0);
      imem_ready   = ($urandom_range(0, 3) != 0);
      br_target_ex  = {$urandom, $urandom};
      jmp_target_id = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) br_target_ex[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jmp_target_id[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0)
        pc_cur = 64'($urandom & 32'h3FFC);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
